alu_arbiter: RTL and testbench

- Shares one ALU datapath between two requesters (e.g. PC-increment path and branch-target path) using a round-robin arbiter.
- Each requester uses a valid/ready handshake. The result is held in a single-entry output register with its own valid/ready handshake.
- Gives one request per cycle throughput and 1-cycle latency. Sits between the requesters and the downstream register/PC logic.

---
 rtl/alu_arb_pkg.sv | 14 +
 rtl/alu_arbiter_if.sv | 42 ++++
 rtl/alu_arbiter_alu_core.sv | 20 ++
 rtl/alu_arbiter.sv | 105 ++++++++++
 tb/tb_alu_arbiter.sv | 245 ++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_arb_pkg.sv
// Shared types for the two-requester ALU arbiter: operation encoding and requester ids.
package alu_arb_pkg;

  typedef enum logic {
    ALU_ADD = 1'b0,
    ALU_SUB = 1'b1
  } alu_op_e;

  typedef logic req_id_t;

  localparam req_id_t REQ0 = 1'b0;
  localparam req_id_t REQ1 = 1'b1;

endpackage

// File: rtl/alu_arbiter_if.sv
// Handshake bundle between two requesters, the arbiter and the result consumer.
// master = requesters/consumer side, slave = arbiter side.
interface alu_arbiter_if #(
  parameter int DATA_WIDTH = 12
);
  import alu_arb_pkg::*;

  logic                  req0_valid;
  logic                  req0_ready;
  logic [DATA_WIDTH-1:0] req0_op1;
  logic [DATA_WIDTH-1:0] req0_op2;
  logic                  req0_sub;

  logic                  req1_valid;
  logic                  req1_ready;
  logic [DATA_WIDTH-1:0] req1_op1;
  logic [DATA_WIDTH-1:0] req1_op2;
  logic                  req1_sub;

  logic                  rsp_valid;
  logic                  rsp_ready;
  req_id_t               rsp_id;
  logic [DATA_WIDTH-1:0] rsp_data;
  logic                  rsp_eq;

  modport master (
    output req0_valid, req0_op1, req0_op2, req0_sub,
    output req1_valid, req1_op1, req1_op2, req1_sub,
    output rsp_ready,
    input  req0_ready, req1_ready,
    input  rsp_valid, rsp_id, rsp_data, rsp_eq
  );

  modport slave (
    input  req0_valid, req0_op1, req0_op2, req0_sub,
    input  req1_valid, req1_op1, req1_op2, req1_sub,
    input  rsp_ready,
    output req0_ready, req1_ready,
    output rsp_valid, rsp_id, rsp_data, rsp_eq
  );

endinterface

// File: rtl/alu_arbiter_alu_core.sv
// Combinational add/subtract (modulo 2^DATA_WIDTH) plus operand equality.
// Zero latency, no flow control.
module alu_core
  import alu_arb_pkg::*;
#(
  parameter int DATA_WIDTH = 12
) (
  input  logic [DATA_WIDTH-1:0] op1,
  input  logic [DATA_WIDTH-1:0] op2,
  input  alu_op_e               op,
  output logic [DATA_WIDTH-1:0] result,
  output logic                  eq
);

  always_comb begin
    result = (op == ALU_SUB) ? (op1 - op2) : (op1 + op2);
    eq     = (op1 == op2);
  end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin share of one ALU between two valid/ready requesters; 1-cycle latency into a
// single-entry result register, stalls both requesters while a result waits. Option: ALU_ARB_STATS_EN.
module alu_arbiter
  import alu_arb_pkg::*;
#(
  parameter int DATA_WIDTH = 12,
  parameter int STAT_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  alu_arbiter_if.slave          bus
`ifdef ALU_ARB_STATS_EN
  ,
  output logic [STAT_WIDTH-1:0] grant_cnt0,
  output logic [STAT_WIDTH-1:0] grant_cnt1
`endif
);

  req_id_t               last_grant;
  req_id_t               gnt_id;
  logic                  gnt_any;
  logic                  can_accept;
  logic                  xfer;

  logic                  rsp_valid_q;
  req_id_t               rsp_id_q;
  logic [DATA_WIDTH-1:0] rsp_data_q;
  logic                  rsp_eq_q;

  logic [DATA_WIDTH-1:0] sel_op1;
  logic [DATA_WIDTH-1:0] sel_op2;
  logic                  sel_sub;
  logic [DATA_WIDTH-1:0] alu_result;
  logic                  alu_eq;

  // The result slot is free either when empty or when it drains this very cycle.
  assign can_accept = !rsp_valid_q || bus.rsp_ready;

  always_comb begin
    gnt_any = bus.req0_valid || bus.req1_valid;
    if (bus.req0_valid && bus.req1_valid)
      gnt_id = (last_grant == REQ0) ? REQ1 : REQ0;
    else if (bus.req1_valid)
      gnt_id = REQ1;
    else
      gnt_id = REQ0;
  end

  assign xfer           = gnt_any && can_accept && !rst;
  assign bus.req0_ready = xfer && (gnt_id == REQ0);
  assign bus.req1_ready = xfer && (gnt_id == REQ1);

  assign sel_op1 = (gnt_id == REQ1) ? bus.req1_op1 : bus.req0_op1;
  assign sel_op2 = (gnt_id == REQ1) ? bus.req1_op2 : bus.req0_op2;
  assign sel_sub = (gnt_id == REQ1) ? bus.req1_sub : bus.req0_sub;

  alu_core #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_alu_core (
    .op1   (sel_op1),
    .op2   (sel_op2),
    .op    (alu_op_e'(sel_sub)),
    .result(alu_result),
    .eq    (alu_eq)
  );

  // last_grant resets to REQ1 so requester 0 wins the first tie.
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= REQ0;
      rsp_data_q  <= '0;
      rsp_eq_q    <= 1'b0;
      last_grant  <= REQ1;
    end else if (xfer) begin
      rsp_valid_q <= 1'b1;
      rsp_id_q    <= gnt_id;
      rsp_data_q  <= alu_result;
      rsp_eq_q    <= alu_eq;
      last_grant  <= gnt_id;
    end else if (rsp_valid_q && bus.rsp_ready) begin
      rsp_valid_q <= 1'b0;
    end
  end

  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_id    = rsp_id_q;
  assign bus.rsp_data  = rsp_data_q;
  assign bus.rsp_eq    = rsp_eq_q;

`ifdef ALU_ARB_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      grant_cnt0 <= '0;
      grant_cnt1 <= '0;
    end else begin
      if (bus.req0_ready && bus.req0_valid && (grant_cnt0 != '1))
        grant_cnt0 <= grant_cnt0 + STAT_WIDTH'(1);
      if (bus.req1_ready && bus.req1_valid && (grant_cnt1 != '1))
        grant_cnt1 <= grant_cnt1 + STAT_WIDTH'(1);
    end
  end
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: directed scenarios with literal expectations, then randomized
// traffic, all checked every cycle against a transaction-level model.
module tb_alu_arbiter;
  import alu_arb_pkg::*;

  localparam int DW   = 12;
  localparam int SW   = 16;
  localparam int MODV = 1 << DW;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  alu_arbiter_if #(.DATA_WIDTH(DW)) bus ();

`ifdef ALU_ARB_STATS_EN
  logic [SW-1:0] grant_cnt0;
  logic [SW-1:0] grant_cnt1;
`endif

  alu_arbiter #(
    .DATA_WIDTH(DW),
    .STAT_WIDTH(SW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
`ifdef ALU_ARB_STATS_EN
    ,
    .grant_cnt0(grant_cnt0),
    .grant_cnt1(grant_cnt1)
`endif
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction-level model: what the result slot holds and who went last.
  bit m_on = 0;
  bit m_valid;
  int m_id, m_data, m_last;
  bit m_eq;
  int m_cnt[2];

  function automatic int alu_model(input int a, input int b, input bit s);
    return s ? ((a - b + MODV) % MODV) : ((a + b) % MODV);
  endfunction

  always @(negedge clk) begin
    bit v[2];
    int a[2], b[2];
    bit s[2];
    int winner;
    bit e_rdy[2];
    v[0] = bus.req0_valid; a[0] = int'(bus.req0_op1); b[0] = int'(bus.req0_op2); s[0] = bus.req0_sub;
    v[1] = bus.req1_valid; a[1] = int'(bus.req1_op1); b[1] = int'(bus.req1_op2); s[1] = bus.req1_sub;
    winner = -1;
    if (v[0] && v[1]) winner = 1 - m_last;
    else if (v[0])    winner = 0;
    else if (v[1])    winner = 1;
    for (int i = 0; i < 2; i++)
      e_rdy[i] = !rst && (winner == i) && (!m_valid || bus.rsp_ready);
    if (m_on) begin
      check("model req0_ready", 32'(bus.req0_ready), 32'(e_rdy[0]));
      check("model req1_ready", 32'(bus.req1_ready), 32'(e_rdy[1]));
      check("model rsp_valid",  32'(bus.rsp_valid),  32'(m_valid));
      check("model rsp_id",     32'(bus.rsp_id),     32'(m_id));
      check("model rsp_data",   32'(bus.rsp_data),   32'(m_data));
      check("model rsp_eq",     32'(bus.rsp_eq),     32'(m_eq));
`ifdef ALU_ARB_STATS_EN
      check("model grant_cnt0", 32'(grant_cnt0), 32'(m_cnt[0]));
      check("model grant_cnt1", 32'(grant_cnt1), 32'(m_cnt[1]));
`endif
    end
    if (rst) begin
      m_on = 1; m_valid = 0; m_id = 0; m_data = 0; m_eq = 0; m_last = 1;
      m_cnt[0] = 0; m_cnt[1] = 0;
    end else if (m_on && winner >= 0 && e_rdy[winner]) begin
      m_valid = 1;
      m_id    = winner;
      m_data  = alu_model(a[winner], b[winner], s[winner]);
      m_eq    = (a[winner] == b[winner]);
      m_last  = winner;
      if (m_cnt[winner] < (1 << SW) - 1) m_cnt[winner]++;
    end else if (m_valid && bus.rsp_ready) begin
      m_valid = 0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int id, input bit v, input int a, input int b, input bit s);
    if (id == 0) begin
      bus.req0_valid = v; bus.req0_op1 = DW'(a); bus.req0_op2 = DW'(b); bus.req0_sub = s;
    end else begin
      bus.req1_valid = v; bus.req1_op1 = DW'(a); bus.req1_op2 = DW'(b); bus.req1_sub = s;
    end
  endtask

  task automatic single(input int id, input int a, input int b, input bit s,
                        input int exp_data, input bit exp_eq);
    set_req(id, 1, a, b, s);
    #1;
    check("single ready", 32'(id == 0 ? bus.req0_ready : bus.req1_ready), 32'd1);
    tick();
    check("single rsp_valid", 32'(bus.rsp_valid), 32'd1);
    check("single rsp_id",    32'(bus.rsp_id),    32'(id));
    check("single rsp_data",  32'(bus.rsp_data),  32'(exp_data));
    check("single rsp_eq",    32'(bus.rsp_eq),    32'(exp_eq));
    set_req(id, 0, a, b, s);
  endtask

  initial begin
    bit acc0, acc1;
    rst = 1'b1;
    bus.rsp_ready = 1'b1;
    set_req(0, 1, 'h7FF, 'h001, 0);
    set_req(1, 1, 'h100, 'h001, 1);
    tick();
    tick();
    // Reset state and no acceptance during reset.
    check("reset rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("reset rsp_id",    32'(bus.rsp_id),    32'd0);
    check("reset rsp_data",  32'(bus.rsp_data),  32'd0);
    check("reset rsp_eq",    32'(bus.rsp_eq),    32'd0);
    check("reset req0_ready", 32'(bus.req0_ready), 32'd0);
    check("reset req1_ready", 32'(bus.req1_ready), 32'd0);
    rst = 1'b0;
    #1;
    check("first tie req0_ready", 32'(bus.req0_ready), 32'd1);
    check("first tie req1_ready", 32'(bus.req1_ready), 32'd0);
    tick();
    check("add 7FF+1 valid", 32'(bus.rsp_valid), 32'd1);
    check("add 7FF+1 id",    32'(bus.rsp_id),    32'd0);
    check("add 7FF+1 data",  32'(bus.rsp_data),  32'h800);
    check("add 7FF+1 eq",    32'(bus.rsp_eq),    32'd0);
    set_req(0, 0, 0, 0, 0);
    #1;
    check("req1 alone ready", 32'(bus.req1_ready), 32'd1);
    tick();
    check("sub 100-1 data", 32'(bus.rsp_data), 32'h0FF);
    check("sub 100-1 id",   32'(bus.rsp_id),   32'd1);

    // Round robin, no gaps: last winner was 1, so 0 leads.
    set_req(0, 1, 'h010, 'h020, 0);
    set_req(1, 1, 'h100, 'h001, 1);
    for (int i = 0; i < 6; i++) begin
      #1;
      check("rr ready", 32'(i % 2 == 0 ? bus.req0_ready : bus.req1_ready), 32'd1);
      tick();
      check("rr rsp_valid", 32'(bus.rsp_valid), 32'd1);
      check("rr rsp_id",    32'(bus.rsp_id),    32'(i % 2));
      check("rr rsp_data",  32'(bus.rsp_data),  (i % 2 == 0) ? 32'h030 : 32'h0FF);
    end

    // Backpressure: result held, both requesters stalled, then pending winner 0 goes at once.
    bus.rsp_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("bp req0_ready", 32'(bus.req0_ready), 32'd0);
      check("bp req1_ready", 32'(bus.req1_ready), 32'd0);
      tick();
      check("bp rsp_valid", 32'(bus.rsp_valid), 32'd1);
      check("bp rsp_id",    32'(bus.rsp_id),    32'd1);
      check("bp rsp_data",  32'(bus.rsp_data),  32'h0FF);
    end
    bus.rsp_ready = 1'b1;
    #1;
    check("bp release req0_ready", 32'(bus.req0_ready), 32'd1);
    check("bp release req1_ready", 32'(bus.req1_ready), 32'd0);
    tick();
    check("bp release rsp_id",   32'(bus.rsp_id),   32'd0);
    check("bp release rsp_data", 32'(bus.rsp_data), 32'h030);
    set_req(0, 0, 0, 0, 0);
    set_req(1, 0, 0, 0, 0);

    // Wrap-around and equality.
    single(0, 'hFFF, 'h002, 0, 'h001, 0);
    single(1, 'h005, 'h005, 1, 'h000, 1);
    single(0, 'h000, 'h001, 1, 'hFFF, 0);
    single(1, 'h123, 'h045, 0, 'h168, 0);

    // Reset while a result is held and req1 waits.
    bus.rsp_ready = 1'b0;
    set_req(1, 1, 'h001, 'h001, 0);
    rst = 1'b1;
    #1;
    check("midrst req1_ready", 32'(bus.req1_ready), 32'd0);
    tick();
    check("midrst rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("midrst rsp_data",  32'(bus.rsp_data),  32'd0);
    rst = 1'b0;
    set_req(0, 1, 'h002, 'h003, 0);
    #1;
    check("midrst tie req0_ready", 32'(bus.req0_ready), 32'd1);
    check("midrst tie req1_ready", 32'(bus.req1_ready), 32'd0);
`ifdef ALU_ARB_STATS_EN
    check("midrst grant_cnt0", 32'(grant_cnt0), 32'd0);
    check("midrst grant_cnt1", 32'(grant_cnt1), 32'd0);
`endif
    tick();
    set_req(0, 0, 0, 0, 0);
    set_req(1, 0, 0, 0, 0);
    bus.rsp_ready = 1'b1;
    tick();

    // Randomized traffic; requesters hold valid and operands until accepted.
    acc0 = 1; acc1 = 1;
    for (int c = 0; c < 3000; c++) begin
      if (acc0 || !bus.req0_valid) begin
        int x = int'($urandom_range(0, MODV - 1));
        set_req(0, $urandom_range(0, 3) != 0, x,
                ($urandom_range(0, 5) == 0) ? x : int'($urandom_range(0, MODV - 1)),
                1'($urandom_range(0, 1)));
      end
      if (acc1 || !bus.req1_valid) begin
        int y = int'($urandom_range(0, MODV - 1));
        set_req(1, $urandom_range(0, 3) != 0, y,
                ($urandom_range(0, 5) == 0) ? y : int'($urandom_range(0, MODV - 1)),
                1'($urandom_range(0, 1)));
      end
      bus.rsp_ready = ($urandom_range(0, 3) != 0);
      rst = ($urandom_range(0, 99) == 0);
      #1;
      acc0 = bus.req0_valid && bus.req0_ready;
      acc1 = bus.req1_valid && bus.req1_ready;
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
